uart_tx_arbiter: RTL

- Shares one UART transmitter between nreq byte requesters. The transmitter takes tx_start/tx_din and returns tx_done.
- Round-robin grant with a bounded per-requester burst, an optional inter-frame guard gap, and a watchdog on missing tx_done.
- Sits between the host-side producers and the serial transmitter. It mirrors the receiver framing width (nbits).

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between nreq byte
// requesters, with burst limit, post-frame guard gap and tx_done watchdog.
module uart_tx_arbiter #(
  parameter int nreq           = 4,
  parameter int nbits          = 8,
  parameter int max_burst      = 4,
  parameter int gap_cycles     = 2,
  parameter int timeout_cycles = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [nreq-1:0]          req_valid,
  input  logic [nreq*nbits-1:0]    req_data,
  output logic [nreq-1:0]          req_ack,
  output logic                     tx_start,
  output logic [nbits-1:0]         tx_din,
  input  logic                     tx_done,
  output logic [$clog2(nreq)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int IW = $clog2(nreq);
  localparam int BW = $clog2(max_burst + 1);
  localparam int TW = timeout_cycles > 0 ? $clog2(timeout_cycles + 1) : 1;
  localparam int GW = gap_cycles > 0 ? $clog2(gap_cycles + 1) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d, grant_q, grant_d, nxt;
  logic [BW-1:0]    burst_q, burst_d;
  logic [TW-1:0]    to_q, to_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [nbits-1:0] din_q, din_d;
  logic [IW:0]      win_idle, win_rot;
  logic             hit, dec, keep;

  // {found, index} of the first valid requester scanning p, p+1, ... mod nreq
  function automatic logic [IW:0] pick(input logic [nreq-1:0] v, input logic [IW-1:0] p);
    logic [IW:0]   r;
    logic [IW-1:0] idx;
    r = '0;
    for (int k = nreq - 1; k >= 0; k--) begin
      idx = IW'((int'(p) + k) % nreq);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [nbits-1:0] byte_of(input logic [nreq*nbits-1:0] d, input logic [IW-1:0] i);
    return d[int'(i)*nbits +: nbits];
  endfunction

  assign nxt      = IW'((int'(grant_q) + 1) % nreq);
  assign win_idle = pick(req_valid, rr_q);
  assign win_rot  = pick(req_valid, nxt);
  assign hit      = timeout_cycles != 0 && to_q == TW'(timeout_cycles);
  assign keep     = req_valid[grant_q] && burst_q < BW'(max_burst);
  assign dec      = (state_q == WAIT && tx_done && gap_cycles == 0) ||
                    (state_q == GAP && gap_q == GW'(gap_cycles - 1));

  assign tx_start = state_q == START;
  assign req_ack  = tx_start ? nreq'(1) << grant_q : '0;
  assign tx_din   = din_q;
  assign grant_id = grant_q;
  assign busy     = state_q != IDLE;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    burst_d     = burst_q;
    din_d       = din_q;
    timeout_err = 1'b0;
    gap_d       = state_q == GAP ? gap_q + 1'b1 : '0;
    to_d        = timeout_cycles == 0 ? '0 :
                  state_q == START ? TW'(1) :
                  (state_q == WAIT && !hit) ? to_q + 1'b1 : '0;
    if (state_q == IDLE && win_idle[IW]) begin
      state_d = START;
      grant_d = win_idle[IW-1:0];
      burst_d = BW'(1);
      din_d   = byte_of(req_data, win_idle[IW-1:0]);
    end
    if (state_q == START) state_d = WAIT;
    if (state_q == WAIT && tx_done && gap_cycles != 0) state_d = GAP;
    // a done arriving on the expiry cycle wins over the watchdog
    if (state_q == WAIT && !tx_done && hit) begin
      timeout_err = 1'b1;
      rr_d        = nxt;
      burst_d     = '0;
      state_d     = IDLE;
    end
    if (dec && keep) begin
      state_d = START;
      burst_d = burst_q + 1'b1;
      din_d   = byte_of(req_data, grant_q);
    end else if (dec) begin
      rr_d    = nxt;
      burst_d = '0;
      state_d = win_rot[IW] ? START : IDLE;
      if (win_rot[IW]) begin
        grant_d = win_rot[IW-1:0];
        burst_d = BW'(1);
        din_d   = byte_of(req_data, win_rot[IW-1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      burst_q <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
    end
  end
endmodule
